// File: rtl/phase_error_tdc.sv
// phase_error_tdc
// Counting phase-error TDC for a digital PLL. It measures the distance, in clk
// cycles, between rising edges of the reference and the divided DCO feedback,
// and reports which of the two came first. If one input edges twice before the
// other edges once, that is a cycle slip.
//
// Build option:
//   TDC_INPUT_SYNC_EN  - pass ref_in/fb_in through two-flop synchronizers before
//                        the sample register. Every edge arrives 2 cycles later;
//                        the measured magnitudes do not change.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no measurement open; waiting for the first edge
// WAIT_FB  | reference edge seen; counting until the feedback edge
// WAIT_REF | feedback edge seen; counting until the reference edge

module phase_error_tdc #(
    parameter int inout_width = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   ref_in,
    input  logic                   fb_in,
    output logic [inout_width-1:0] tdc_out,
    output logic                   lead,
    output logic                   valid,
    output logic                   slip
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_FB  = 2'd1,
        WAIT_REF = 2'd2
    } state_t;

    localparam logic [inout_width-1:0] cnt_max = '1;
    localparam logic [inout_width-1:0] cnt_one = inout_width'(1);

    logic ref_d, fb_d;

`ifdef TDC_INPUT_SYNC_EN
    // Three register stages up to ref_q/fb_q, so warm-up takes three clocks.
    localparam logic [1:0] warm_max = 2'd3;

    logic ref_s1, ref_s2, fb_s1, fb_s2;

    // Two-flop synchronizers for the asynchronous clock inputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ref_s1 <= 1'b0;
            ref_s2 <= 1'b0;
            fb_s1  <= 1'b0;
            fb_s2  <= 1'b0;
        end else begin
            ref_s1 <= ref_in;
            ref_s2 <= ref_s1;
            fb_s1  <= fb_in;
            fb_s2  <= fb_s1;
        end
    end

    assign ref_d = ref_s2;
    assign fb_d  = fb_s2;
`else
    localparam logic [1:0] warm_max = 2'd1;

    assign ref_d = ref_in;
    assign fb_d  = fb_in;
`endif

    logic       ref_q, fb_q, ref_prev, fb_prev;
    logic       ref_arm, fb_arm;
    logic [1:0] warm;
    logic       warm_done;
    logic       ref_edge, fb_edge;

    // The arm bits stop an input that is already high when reset is released
    // from looking like a rising edge. An input is armed only after a real
    // sample of 0 has been seen, which is possible once the pipeline holds
    // post-reset data (warm_done).
    assign warm_done = (warm == warm_max);
    assign ref_edge  = ref_q & ~ref_prev & ref_arm;
    assign fb_edge   = fb_q & ~fb_prev & fb_arm;

    // Sample register, edge history and arming
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ref_q    <= 1'b0;
            fb_q     <= 1'b0;
            ref_prev <= 1'b0;
            fb_prev  <= 1'b0;
            ref_arm  <= 1'b0;
            fb_arm   <= 1'b0;
            warm     <= 2'd0;
        end else begin
            ref_q    <= ref_d;
            fb_q     <= fb_d;
            ref_prev <= ref_q;
            fb_prev  <= fb_q;
            ref_arm  <= ref_arm | (warm_done & ~ref_q);
            fb_arm   <= fb_arm | (warm_done & ~fb_q);
            if (!warm_done) begin
                warm <= warm + 2'd1;
            end
        end
    end

    state_t                 state;
    logic [inout_width-1:0] cnt;
    logic [inout_width-1:0] cnt_nxt;

    // The counter saturates at cnt_max, so a very long gap reads as full scale.
    assign cnt_nxt = (cnt == cnt_max) ? cnt : cnt + cnt_one;

    // Measurement FSM with registered result, valid and slip outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            tdc_out <= '0;
            lead    <= 1'b0;
            valid   <= 1'b0;
            slip    <= 1'b0;
        end else begin
            valid <= 1'b0;
            slip  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ref_edge && fb_edge) begin
                        tdc_out <= '0;
                        lead    <= 1'b0;
                        valid   <= 1'b1;
                    end else if (ref_edge) begin
                        state <= WAIT_FB;
                        cnt   <= cnt_one;
                    end else if (fb_edge) begin
                        state <= WAIT_REF;
                        cnt   <= cnt_one;
                    end
                end
                WAIT_FB: begin
                    // A closing edge wins over a coincident opening edge.
                    if (fb_edge) begin
                        tdc_out <= cnt;
                        lead    <= 1'b0;
                        valid   <= 1'b1;
                        state   <= IDLE;
                        cnt     <= '0;
                    end else if (ref_edge) begin
                        tdc_out <= cnt_max;
                        lead    <= 1'b0;
                        valid   <= 1'b1;
                        slip    <= 1'b1;
                        cnt     <= cnt_one;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                WAIT_REF: begin
                    if (ref_edge) begin
                        tdc_out <= cnt;
                        lead    <= 1'b1;
                        valid   <= 1'b1;
                        state   <= IDLE;
                        cnt     <= '0;
                    end else if (fb_edge) begin
                        tdc_out <= cnt_max;
                        lead    <= 1'b1;
                        valid   <= 1'b1;
                        slip    <= 1'b1;
                        cnt     <= cnt_one;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_error_tdc.sv
// Directed testbench for phase_error_tdc. It builds with or without
// TDC_INPUT_SYNC_EN; only the expected latency and the bench-side gaps differ.

module tb_phase_error_tdc;

    logic       clk = 1'b0;
    logic       rstn;
    logic       ref_in;
    logic       fb_in;
    logic [7:0] tdc_out;
    logic       lead;
    logic       valid;
    logic       slip;

    int errors = 0;
    int checks = 0;
    int vcnt   = 0;
    int orphan = 0;

    // Counted in negedges from the drive point (posedge+1) to the negedge on
    // which valid is first seen high.
`ifdef TDC_INPUT_SYNC_EN
    localparam int EXP_LAT = 5;
`else
    localparam int EXP_LAT = 3;
`endif

    always #5 clk = ~clk;

    phase_error_tdc #(.inout_width(8)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .ref_in  (ref_in),
        .fb_in   (fb_in),
        .tdc_out (tdc_out),
        .lead    (lead),
        .valid   (valid),
        .slip    (slip)
    );

    // Count valid pulses, and any slip pulse that arrives without valid
    always @(negedge clk) begin
        if (valid) vcnt++;
        if (slip && !valid) orphan++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drop();
        ref_in = 1'b0;
        fb_in  = 1'b0;
        cyc(4);
    endtask

    // Wait a bounded time for valid after the closing edge was driven, then
    // check the result, that the pulse lasts one cycle, and that exactly one
    // pulse occurred.
    task automatic measure(input string tag, input int exp_tdc, input int exp_lead,
                           input int exp_slip);
        int n;
        int v0;
        bit found;
        v0    = vcnt;
        n     = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            n++;
            if (valid) found = 1'b1;
        end
        if (!found) n = -1;
        check({tag, ".lat"}, n, EXP_LAT);
        check({tag, ".tdc"}, tdc_out, exp_tdc);
        check({tag, ".lead"}, lead, exp_lead);
        check({tag, ".slip"}, slip, exp_slip);
        @(negedge clk);
        check({tag, ".width"}, valid, 0);
        #1;
        check({tag, ".count"}, vcnt - v0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        rstn   = 1'b0;
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.tdc", tdc_out, 0);
        check("rst.lead", lead, 0);
        check("rst.valid", valid, 0);
        check("rst.slip", slip, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc(10);

        // Reference leads by 5
        ref_in = 1'b1;
        cyc(5);
        fb_in = 1'b1;
        measure("ref_lead5", 5, 0, 0);
        drop();

        // Feedback leads by 3
        fb_in = 1'b1;
        cyc(3);
        ref_in = 1'b1;
        measure("fb_lead3", 3, 1, 0);
        cyc(5);
        check("hold.tdc", tdc_out, 3);
        check("hold.lead", lead, 1);
        drop();

        // Both inputs rise in the same cycle
        ref_in = 1'b1;
        fb_in  = 1'b1;
        measure("same", 0, 0, 0);
        drop();

        // Reference slip: no feedback for 300 cycles, then another ref edge
        v0     = vcnt;
        ref_in = 1'b1;
        cyc(3);
        ref_in = 1'b0;
        cyc(297);
        check("slip.quiet", vcnt - v0, 0);
        ref_in = 1'b1;
        measure("slip_fb", 255, 0, 1);
        cyc(4);
        fb_in = 1'b1;
        measure("post_slip_fb", EXP_LAT + 4, 0, 0);
        drop();

        // Feedback slip in WAIT_REF
        fb_in = 1'b1;
        cyc(3);
        fb_in = 1'b0;
        cyc(7);
        fb_in = 1'b1;
        measure("slip_ref", 255, 1, 1);
        cyc(2);
        ref_in = 1'b1;
        measure("post_slip_ref", EXP_LAT + 2, 1, 0);
        drop();

        // Closing and opening edges coincide: closing wins, back to IDLE
        ref_in = 1'b1;
        cyc(2);
        ref_in = 1'b0;
        cyc(4);
        ref_in = 1'b1;
        fb_in  = 1'b1;
        measure("coincide", 6, 0, 0);
        drop();
        fb_in = 1'b1;
        cyc(2);
        ref_in = 1'b1;
        measure("after_coincide", 2, 1, 0);
        drop();

        // Counter saturates without a slip
        ref_in = 1'b1;
        cyc(260);
        fb_in = 1'b1;
        measure("saturate", 255, 0, 0);
        drop();

        // Reset in the middle of a measurement
        v0     = vcnt;
        ref_in = 1'b1;
        cyc(4);
        rstn = 1'b0;
        #1;
        check("midrst.tdc", tdc_out, 0);
        check("midrst.valid", valid, 0);
        cyc(2);
        rstn = 1'b0;
        cyc(2);
        rstn = 1'b1;
        cyc(3);
        fb_in = 1'b1;
        cyc(20);
        check("midrst.novalid", vcnt - v0, 0);
        check("midrst.tdc_after", tdc_out, 0);
        check("midrst.lead_after", lead, 0);
        check("midrst.slip_after", slip, 0);
        check("orphan_slip", orphan, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phase_error_tdc.md
PHASE_ERROR_TDC -- requirements
Module: phase_error_tdc

Interface
REQ-001 SHALL have parameter: inout_width, 8, magnitude width in bits, matching the loop filter input width.
REQ-002 SHALL have port: clk  input  1  filter/measurement clock; all state updates on its rising edge.
REQ-003 SHALL have port: rstn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: ref_in  input  1  reference clock.
REQ-005 SHALL have port: fb_in  input  1  divided DCO feedback clock.
REQ-006 SHALL have port: tdc_out  output  inout_width  unsigned phase-error magnitude in clk cycles.
REQ-007 SHALL have port: lead  output  1  1 = feedback leads, 0 = reference leads.
REQ-008 SHALL have port: valid  output  1  one-cycle pulse marking new tdc_out/lead.
REQ-009 SHALL have port: slip  output  1  one-cycle pulse marking a cycle slip.

Function
REQ-010 SHALL detect rising edges on ref_in and fb_in by comparing the current registered sample with the previous one; an edge is flagged for exactly one cycle.
REQ-011 SHALL implement FSM states IDLE, WAIT_FB, WAIT_REF.
REQ-012 In IDLE: ref edge only -> WAIT_FB, cnt=1; fb edge only -> WAIT_REF, cnt=1; both edges same cycle -> stay IDLE and emit tdc_out=0, lead=0.
REQ-013 In WAIT_FB/WAIT_REF, cnt SHALL increment by 1 per cycle and saturate at 2^inout_width-1 (255 default), never wrapping.
REQ-014 In WAIT_FB, a fb edge SHALL emit tdc_out=cnt, lead=0 and return to IDLE; in WAIT_REF, a ref edge SHALL emit tdc_out=cnt, lead=1 and return to IDLE.
REQ-015 Cycle slip: in WAIT_FB a further ref edge without fb edge, or in WAIT_REF a further fb edge without ref edge, SHALL emit tdc_out=2^inout_width-1 with the pending lead value, pulse slip, reload cnt=1 and stay in the same state.
REQ-016 If the closing and the opening edge occur in the same cycle in a wait state, the closing edge SHALL be processed per REQ-014 and the slip rule SHALL NOT apply; the FSM SHALL return to IDLE.
REQ-017 "Emit" SHALL mean: tdc_out and lead registered and valid asserted in the cycle after the edge is flagged; valid high exactly one cycle.
REQ-018 tdc_out and lead SHALL hold their last emitted value while valid is low.
REQ-019 slip SHALL assert only coincident with valid.
REQ-020 Latency from closing edge flagged to valid SHALL be exactly 1 clk cycle, plus synchronizer latency per REQ-025.

Reset
REQ-021 While rstn is low: state=IDLE, cnt=0, tdc_out=0, lead=0, valid=0, slip=0, edge-history registers=0.
REQ-022 Reset asserted mid-measurement SHALL abandon the measurement with no valid pulse after release.
REQ-023 After rstn release, an input already high SHALL NOT be flagged as an edge; only a subsequent 0->1 transition counts.

Configuration
REQ-024 Macro TDC_INPUT_SYNC_EN SHALL select input synchronizers.
REQ-025 With TDC_INPUT_SYNC_EN defined: ref_in and fb_in each pass through a two-flop synchronizer before edge detection, adding 2 cycles of latency to every edge.
REQ-026 Without TDC_INPUT_SYNC_EN: ref_in and fb_in are treated as synchronous to clk and registered once before edge detection; measured magnitudes are identical in both builds.

Verification
REQ-027 Ref rises at cycle 10, fb at cycle 15 -> one valid pulse, tdc_out=5, lead=0, slip=0.
REQ-028 Fb rises at cycle 20, ref at cycle 23 -> one valid pulse, tdc_out=3, lead=1.
REQ-029 Ref and fb rise in the same cycle -> valid pulse, tdc_out=0, lead=0.
REQ-030 Ref rises, no fb for 300 cycles -> no valid until the next ref edge; then tdc_out=255, slip=1, new measurement started.
REQ-031 Ref rises, rstn pulsed low 4 cycles later, fb rises afterwards -> no valid pulse; all outputs 0.
REQ-032 Run REQ-027 in both macro builds -> identical tdc_out/lead, valid 2 cycles later with TDC_INPUT_SYNC_EN.
